endec_iter: RTL and testbench

Parametrised iterative round cipher engine, the next generation of the 4-bit encoder/decoder. It runs a configurable number of XOR/invert/rotate rounds over a DATA_W-bit word, one round per clock, in encrypt or decrypt mode. Transactions use valid/ready handshakes on both sides. It sits between the pin-level input capture and the output register stage of the tile.

---
 rtl/endec_pkg.sv | 47 ++++
 rtl/endec_iter_round.sv | 25 ++
 rtl/endec_iter.sv | 128 ++++++++++++
 tb/tb_endec_iter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/endec_pkg.sv
// endec_pkg: state type and round helpers shared by the endec_iter engine.
// Helpers work on a MAX_W-bit container and mask to the requested width.
package endec_pkg;

    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic word_t width_mask(input int w);
        word_t m;
        if (w >= MAX_W) m = '1;
        else            m = (word_t'(1'b1) << w) - word_t'(1'b1);
        return m;
    endfunction

    function automatic word_t rotl(input word_t x, input int amt, input int w);
        word_t m;
        word_t v;
        int    a;
        m = width_mask(w);
        v = x & m;
        a = amt % w;
        if (a == 0) return v;
        else        return ((v << a) | (v >> (w - a))) & m;
    endfunction

    function automatic word_t rotr(input word_t x, input int amt, input int w);
        return rotl(x, w - (amt % w), w);
    endfunction

    // Encrypt: invert the keyed word, then rotate left.
    function automatic word_t enc_round(input word_t x, input word_t k, input int rot, input int w);
        return rotl(~(x ^ k), rot, w);
    endfunction

    // Decrypt undoes enc_round step by step in reverse order.
    function automatic word_t dec_round(input word_t x, input word_t k, input int rot, input int w);
        return (~rotr(x, rot, w) ^ k) & width_mask(w);
    endfunction

endpackage

// File: rtl/endec_iter_round.sv
// endec_round: one combinational encrypt/decrypt round of the iterative engine.
module endec_round
    import endec_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ROT    = DATA_W / 2
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] k,
    input  logic              mode,
    output logic [DATA_W-1:0] y
);

    word_t r;

    // Select the round direction from the latched mode.
    always_comb begin
        r = '0;
        if (mode) r = dec_round(word_t'(x), word_t'(k), ROT, DATA_W);
        else      r = enc_round(word_t'(x), word_t'(k), ROT, DATA_W);
    end

    assign y = r[DATA_W-1:0];

endmodule

// File: rtl/endec_iter.sv
// endec_iter: iterative XOR/invert/rotate cipher, one round per clock, valid/ready on both sides.
// Optional per-round key schedule is built when ENDEC_KEY_SCHEDULE_EN is defined.
module endec_iter
    import endec_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ROUND_W = 4,
    parameter int ROT     = DATA_W / 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [DATA_W-1:0]  code_i,
    input  logic [DATA_W-1:0]  key_i,
    input  logic [ROUND_W-1:0] rounds_i,
    input  logic               mode_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DATA_W-1:0]  code_o,
    output logic               busy_o
);

    state_t              state;
    logic                ready;
    logic [DATA_W-1:0]   data;
    logic [DATA_W-1:0]   key;
    logic [ROUND_W-1:0]  cnt;
    logic                mode;
    logic [DATA_W-1:0]   round_y;
    logic [DATA_W-1:0]   start_key;
    logic [DATA_W-1:0]   next_key;
    logic                accept;

    // Ready is forced low while reset is held so no request is taken during reset.
    assign in_ready_o = ready & ~rst_i;
    assign accept     = in_valid_i & in_ready_o;

    endec_round #(.DATA_W(DATA_W), .ROT(ROT)) u_round (
        .x    (data),
        .k    (key),
        .mode (mode),
        .y    (round_y)
    );

`ifdef ENDEC_KEY_SCHEDULE_EN
    // The key register is the working key: decrypt starts at the last encrypt key and walks back.
    always_comb begin
        start_key = key_i;
        next_key  = key;
        if (mode_i && (rounds_i != '0))
            start_key = DATA_W'(rotl(word_t'(key_i), int'({1'b0, rounds_i}) - 1, DATA_W));
        else
            start_key = key_i;
        if (mode) next_key = DATA_W'(rotr(word_t'(key), 1, DATA_W));
        else      next_key = DATA_W'(rotl(word_t'(key), 1, DATA_W));
    end
`else
    assign start_key = key_i;
    assign next_key  = key;
`endif

    // Control FSM and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            ready       <= 1'b1;
            out_valid_o <= 1'b0;
            code_o      <= '0;
            busy_o      <= 1'b0;
            data        <= '0;
            key         <= '0;
            cnt         <= '0;
            mode        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ready  <= 1'b0;
                        busy_o <= 1'b1;
                        mode   <= mode_i;
                        data   <= code_i;
                        key    <= start_key;
                        cnt    <= rounds_i;
                        if (rounds_i == '0) begin
                            state       <= DONE;
                            out_valid_o <= 1'b1;
                            code_o      <= code_i;
                        end else begin
                            state <= RUN;
                        end
                    end else begin
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    data <= round_y;
                    key  <= next_key;
                    cnt  <= cnt - ROUND_W'(1);
                    if (cnt == ROUND_W'(1)) begin
                        state       <= DONE;
                        out_valid_o <= 1'b1;
                        code_o      <= round_y;
                    end else begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state       <= IDLE;
                        out_valid_o <= 1'b0;
                        ready       <= 1'b1;
                        busy_o      <= 1'b0;
                    end else begin
                        state <= DONE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    ready       <= 1'b1;
                    out_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_endec_iter.sv
// Self-checking bench for endec_iter (DATA_W=8, ROUND_W=4, ROT=4) with a queue-based scoreboard.
module tb_endec_iter;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] code_i;
    logic [7:0] key_i;
    logic [3:0] rounds_i;
    logic       mode_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [7:0] code_o;
    logic       busy_o;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    int         lat_q[$];

    always #5 clk = ~clk;

    endec_iter #(.DATA_W(8), .ROUND_W(4), .ROT(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .code_i      (code_i),
        .key_i       (key_i),
        .rounds_i    (rounds_i),
        .mode_i      (mode_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .code_o      (code_o),
        .busy_o      (busy_o)
    );

    function automatic logic [7:0] rl8(input logic [7:0] v, input int a);
        logic [15:0] d;
        int s;
        d = {v, v};
        s = a % 8;
        return d[15 - s -: 8];
    endfunction

    function automatic logic [7:0] rr8(input logic [7:0] v, input int a);
        return rl8(v, (8 - (a % 8)) % 8);
    endfunction

    function automatic logic [7:0] round_key(input logic [7:0] k, input int i);
`ifdef ENDEC_KEY_SCHEDULE_EN
        return rl8(k, i % 8);
`else
        return k;
`endif
    endfunction

    function automatic logic [7:0] model_enc(input logic [7:0] x, input logic [7:0] k, input int n);
        logic [7:0] v;
        v = x;
        for (int i = 0; i < n; i++) v = rl8(~(v ^ round_key(k, i)), 4);
        return v;
    endfunction

    function automatic logic [7:0] model_dec(input logic [7:0] x, input logic [7:0] k, input int n);
        logic [7:0] v;
        v = x;
        for (int i = n - 1; i >= 0; i--) v = ~rr8(v, 4) ^ round_key(k, i);
        return v;
    endfunction

    task automatic run_txn(input logic [7:0] c, input logic [7:0] k, input logic [3:0] n,
                           input logic m, input string tag, output logic [7:0] res);
        int waitc;
        int lat;
        logic [7:0] e;
        int el;
        res   = 8'h00;
        waitc = 0;
        @(negedge clk);
        while (!in_ready_o && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        vectors++;
        if (in_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready_wait: in_ready_o=%b required 1", tag, in_ready_o);
            return;
        end
        code_i = c; key_i = k; rounds_i = n; mode_i = m; in_valid_i = 1'b1;
        exp_q.push_back(m ? model_dec(c, k, int'(n)) : model_enc(c, k, int'(n)));
        lat_q.push_back(int'(n));
        @(negedge clk);
        in_valid_i = 1'b0;
        code_i     = 8'($urandom);
        key_i      = 8'($urandom);
        rounds_i   = 4'($urandom);
        mode_i     = ~m;
        lat = 0;
        while (!out_valid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        vectors++;
        if (out_valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s out_valid_timeout: out_valid_o=%b required 1", tag, out_valid_o);
        end
        vectors++;
        if (code_o !== e) begin
            miscompares++;
            $display("FAIL %s code: code_o=%h required %h", tag, code_o, e);
        end
        vectors++;
        if (lat != el) begin
            miscompares++;
            $display("FAIL %s latency: got %0d required %0d", tag, lat, el);
        end
        res = code_o;
        @(negedge clk);
        vectors++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s consume: out_valid_o=%b busy_o=%b required 0 0", tag, out_valid_o, busy_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
        code_i = 8'h00; key_i = 8'h00; rounds_i = 4'h0; mode_i = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (out_valid_o !== 1'b0 || code_o !== 8'h00 || busy_o !== 1'b0 || in_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: valid=%b code=%h busy=%b ready=%b required 0 00 0 0",
                     out_valid_o, code_o, busy_o, in_ready_o);
        end
        rst_i = 1'b0;
        #1;
        vectors++;
        if (in_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: in_ready_o=%b required 1", in_ready_o);
        end
    endtask

    task automatic test_directed();
        logic [7:0] r;
        logic [7:0] e2;
`ifdef ENDEC_KEY_SCHEDULE_EN
        e2 = 8'hFC;
`else
        e2 = 8'hED;
`endif
        run_txn(8'h12, 8'h0F, 4'd1, 1'b0, "enc_n1", r);
        vectors++;
        if (r !== 8'h2E) begin miscompares++; $display("FAIL enc_n1_const: got %h required 2e", r); end
        run_txn(8'h2E, 8'h0F, 4'd1, 1'b1, "dec_n1", r);
        vectors++;
        if (r !== 8'h12) begin miscompares++; $display("FAIL dec_n1_const: got %h required 12", r); end
        run_txn(8'h12, 8'h0F, 4'd2, 1'b0, "enc_n2", r);
        vectors++;
        if (r !== e2) begin miscompares++; $display("FAIL enc_n2_const: got %h required %h", r, e2); end
        run_txn(e2, 8'h0F, 4'd2, 1'b1, "dec_n2", r);
        vectors++;
        if (r !== 8'h12) begin miscompares++; $display("FAIL dec_n2_const: got %h required 12", r); end
    endtask

    task automatic test_n0_hold();
        int waitc;
        logic [7:0] e;
        waitc = 0;
        @(negedge clk);
        while (!in_ready_o && waitc < 50) begin @(negedge clk); waitc++; end
        out_ready_i = 1'b0;
        code_i = 8'hA5; key_i = 8'h3C; rounds_i = 4'd0; mode_i = 1'b0; in_valid_i = 1'b1;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        in_valid_i = 1'b0;
        code_i = 8'h00;
        e = exp_q.pop_front();
        vectors++;
        if (out_valid_o !== 1'b1 || code_o !== e) begin
            miscompares++;
            $display("FAIL n0_latency: valid=%b code=%h required 1 %h", out_valid_o, code_o, e);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid_o !== 1'b1 || code_o !== e || in_ready_o !== 1'b0) begin
                miscompares++;
                $display("FAIL n0_hold[%0d]: valid=%b code=%h ready=%b required 1 %h 0",
                         i, out_valid_o, code_o, in_ready_o, e);
            end
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL n0_release: valid=%b ready=%b required 0 1", out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_roundtrip();
        logic [7:0] x, k, c, r;
        logic [3:0] n;
        for (int i = 0; i < 1000; i++) begin
            x = 8'($urandom); k = 8'($urandom); n = 4'($urandom_range(0, 15));
            run_txn(x, k, n, 1'b0, "rt_enc", c);
            run_txn(c, k, n, 1'b1, "rt_dec", r);
            vectors++;
            if (r !== x) begin
                miscompares++;
                $display("FAIL roundtrip: x=%h key=%h n=%0d dec=%h required %h", x, k, n, r, x);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, last_acc, acc_cnt, done_cnt;
        int last_n;
        logic pending, have_last;
        logic [7:0] e;
        cyc = 0; acc_cnt = 0; done_cnt = 0; last_acc = 0; last_n = 0;
        pending = 1'b0; have_last = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        code_i = 8'($urandom); key_i = 8'($urandom); rounds_i = 4'($urandom); mode_i = 1'($urandom);
        in_valid_i = 1'b1;
        while (done_cnt < 40 && cyc < 2000) begin
            if (out_valid_o) begin
                e = exp_q.pop_front();
                lat_q.delete();
                vectors++;
                if (code_o !== e) begin
                    miscompares++;
                    $display("FAIL b2b_code[%0d]: code_o=%h required %h", done_cnt, code_o, e);
                end
                done_cnt++;
            end
            if (pending) begin
                pending = 1'b0;
                if (acc_cnt >= 40) in_valid_i = 1'b0;
                else begin
                    code_i = 8'($urandom); key_i = 8'($urandom);
                    rounds_i = 4'($urandom); mode_i = 1'($urandom);
                end
            end
            if (in_ready_o && in_valid_i) begin
                if (have_last) begin
                    vectors++;
                    if (cyc - last_acc != last_n + 2) begin
                        miscompares++;
                        $display("FAIL b2b_spacing: got %0d required %0d", cyc - last_acc, last_n + 2);
                    end
                end
                exp_q.push_back(mode_i ? model_dec(code_i, key_i, int'(rounds_i))
                                       : model_enc(code_i, key_i, int'(rounds_i)));
                last_acc = cyc; last_n = int'(rounds_i); have_last = 1'b1;
                acc_cnt++; pending = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid_i = 1'b0;
        vectors++;
        if (done_cnt != 40) begin
            miscompares++;
            $display("FAIL b2b_timeout: completed %0d required 40", done_cnt);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int waitc;
        logic [7:0] r;
        waitc = 0;
        out_ready_i = 1'b1;
        @(negedge clk);
        while (!in_ready_o && waitc < 50) begin @(negedge clk); waitc++; end
        code_i = 8'h3C; key_i = 8'h55; rounds_i = 4'd10; mode_i = 1'b0; in_valid_i = 1'b1;
        exp_q.push_back(model_enc(8'h3C, 8'h55, 10));
        @(negedge clk);
        in_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy_o !== 1'b1 || out_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_running: busy=%b valid=%b required 1 0", busy_o, out_valid_o);
        end
        rst_i = 1'b1;
        @(negedge clk);
        exp_q.delete();
        vectors++;
        if (out_valid_o !== 1'b0 || code_o !== 8'h00 || busy_o !== 1'b0 || in_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: valid=%b code=%h busy=%b ready=%b required 0 00 0 0",
                     out_valid_o, code_o, busy_o, in_ready_o);
        end
        rst_i = 1'b0;
        #1;
        vectors++;
        if (in_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_release_ready: in_ready_o=%b required 1", in_ready_o);
        end
        run_txn(8'h12, 8'h0F, 4'd1, 1'b0, "after_reset", r);
        vectors++;
        if (r !== 8'h2E) begin miscompares++; $display("FAIL after_reset_const: got %h required 2e", r); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_n0_hold();
        test_roundtrip();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
